// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and types for the instruction-memory loader.
package instr_mem_loader_pkg;

    localparam int unsigned IMEM_DEPTH = 256;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        LDR_IDLE,
        LDR_LOAD,
        LDR_RUN
    } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Program-load stream plus core fetch/reset signals of the instruction-memory loader.
interface instr_mem_loader_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   load_start;
    logic                   load_valid;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   load_last;
    logic                   load_ready;
    logic                   load_done;
    logic                   load_err;
    logic                   core_rst_n;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   pc_err;

    modport master (
        output load_start, load_valid, load_data, load_last, pc,
        input  load_ready, load_done, load_err, core_rst_n, instr, pc_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, pc,
        output load_ready, load_done, load_err, core_rst_n, instr, pc_err
    );
endinterface

// File: rtl/instr_mem_loader_mem.sv
// Instruction storage: synchronous write port, asynchronous read port, no reset.
module instr_mem_loader_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program into instruction storage, holds the core in reset until the load
// completes, then serves instruction fetches from pc.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH       = IMEM_DEPTH,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_loader_if.slave bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;
    localparam logic [CntW-1:0]     LastIdx = CntW'(DEPTH - 1);
    localparam logic [PC_WIDTH-1:0] PcLimit = PC_WIDTH'(DEPTH * 4);

    loader_state_e    state_q;
    logic [CntW-1:0]  wr_cnt_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic             core_rst_n_q;

    logic                   beat;
    logic                   pc_bad;
    logic                   in_run;
    logic [INSTR_WIDTH-1:0] rd_data;

    assign beat = (state_q == LDR_LOAD) && bus.load_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LDR_IDLE;
            wr_cnt_q     <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            unique case (state_q)
                LDR_IDLE: begin
                    ready_q      <= 1'b0;
                    done_q       <= 1'b0;
                    core_rst_n_q <= 1'b0;
                    if (bus.load_start) begin
                        state_q  <= LDR_LOAD;
                        wr_cnt_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                LDR_LOAD: begin
                    ready_q <= 1'b1;
                    if (beat) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        // Filling the last slot without load_last ends the load as an overflow.
                        if (bus.load_last || (wr_cnt_q == LastIdx)) begin
                            state_q <= LDR_RUN;
                            ready_q <= 1'b0;
                            if (!bus.load_last) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                LDR_RUN: begin
                    ready_q <= 1'b0;
                    if (bus.load_start) begin
                        state_q      <= LDR_LOAD;
                        wr_cnt_q     <= '0;
                        err_q        <= 1'b0;
                        done_q       <= 1'b0;
                        core_rst_n_q <= 1'b0;
                    end else begin
                        done_q       <= 1'b1;
                        core_rst_n_q <= 1'b1;
                    end
                end
                default: state_q <= LDR_IDLE;
            endcase
        end
    end

    instr_mem_loader_mem #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (beat),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (bus.load_data),
        .raddr_i (bus.pc[AW+1:2]),
        .rdata_o (rd_data)
    );

    assign in_run = (state_q == LDR_RUN);
    assign pc_bad = (bus.pc[1:0] != 2'b00) || (bus.pc >= PcLimit);

    assign bus.load_ready = ready_q;
    assign bus.load_done  = done_q;
    assign bus.load_err   = err_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.instr      = (in_run && !pc_bad) ? rd_data : INSTR_WIDTH'(NOP_INSTR);
    assign bus.pc_err     = in_run && pc_bad;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected observations, a negedge
// monitor pops and compares them.
module tb_instr_mem_loader;
    localparam int unsigned DEPTH = 4;

    localparam logic [39:0] M_CNT = 40'hE0_0000_0000;
    localparam logic [39:0] M_FLG = 40'h1F_0000_0000;
    localparam logic [39:0] M_INS = 40'h00_FFFF_FFFF;
    localparam logic [39:0] M_ALL = M_CNT | M_FLG | M_INS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    instr_mem_loader #(
        .DEPTH       (DEPTH),
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {wr_cnt, ready, done, err, core_rst_n, pc_err, instr}
    logic [39:0] obs;
    assign obs = {dut.wr_cnt_q, bus.load_ready, bus.load_done, bus.load_err,
                  bus.core_rst_n, bus.pc_err, bus.instr};

    typedef struct {
        string       name;
        logic [39:0] exp;
        logic [39:0] mask;
        bit          timeout;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [39:0] mk(input logic [2:0] c, input logic r, input logic d,
                                       input logic e, input logic n, input logic p,
                                       input logic [31:0] i);
        return {c, r, d, e, n, p, i};
    endfunction

    task automatic expect_obs(input string nm, input logic [39:0] e, input logic [39:0] m);
        chk_t c;
        c.name = nm;
        c.exp = e;
        c.mask = m;
        c.timeout = 1'b0;
        sb.push_back(c);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            c = sb.pop_front();
            n_cmp++;
            if (c.timeout) begin
                n_bad++;
                $display("FAIL %s: handshake never completed, required a beat", c.name);
            end else if ((obs & c.mask) !== (c.exp & c.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h required %h (mask %h)", c.name, obs & c.mask,
                         c.exp & c.mask, c.mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        chk_t c;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = l;
        for (int i = 0; i < 8; i++) begin
            if (bus.load_ready) begin
                tick();
                bus.load_valid = 1'b0;
                bus.load_last  = 1'b0;
                return;
            end
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        c.name = "send_timeout";
        c.exp = '0;
        c.mask = '0;
        c.timeout = 1'b1;
        sb.push_back(c);
    endtask

    task automatic start_pulse();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    // Read in RUN with the core released.
    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] w,
                      input logic pe);
        bus.pc = a;
        expect_obs(nm, mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b1, pe, w), M_FLG | M_INS);
        tick();
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.pc         = 32'h2;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        expect_obs("reset_idle", mk(3'd0, 0, 0, 0, 0, 0, 32'h0), M_ALL);
        bus.pc = 32'h0;

        // Basic load
        start_pulse();
        expect_obs("load_entry", mk(3'd0, 0, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        send(32'h2008_0005, 1'b0);
        send(32'h2009_000C, 1'b0);
        send(32'hAC08_0004, 1'b1);
        expect_obs("last_beat_edge", mk(3'd3, 0, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        tick();
        expect_obs("basic_done", mk(3'd3, 0, 1, 0, 1, 0, 32'h2008_0005), M_ALL);
        tick();
        rd("basic_pc4", 32'd4, 32'h2009_000C, 1'b0);
        rd("basic_pc8", 32'd8, 32'hAC08_0004, 1'b0);
        bus.pc = 32'd12;
        expect_obs("basic_pc12", mk(3'd0, 0, 1, 0, 1, 0, 32'h0), M_FLG);
        tick();
        bus.pc = 32'd0;

        // Stalled stream; junk data during stalls must not be written
        start_pulse();
        expect_obs("reload_entry", mk(3'd0, 0, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        tick();
        expect_obs("ready_up", mk(3'd0, 1, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        bus.load_valid = 1'b1; bus.load_data = 32'h2008_0005; tick();
        bus.load_valid = 1'b0; bus.load_data = 32'hDEAD_BEEF; tick();
        tick();
        expect_obs("stall_cnt1", mk(3'd1, 1, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        bus.load_valid = 1'b1; bus.load_data = 32'h2009_000C; tick();
        bus.load_valid = 1'b0; bus.load_data = 32'hDEAD_BEEF; tick();
        bus.load_valid = 1'b1; bus.load_data = 32'hAC08_0004; bus.load_last = 1'b1; tick();
        bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.load_data = 32'hDEAD_BEEF;
        expect_obs("stall_cnt3", mk(3'd3, 0, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        tick();
        rd("stall_pc0", 32'd0, 32'h2008_0005, 1'b0);
        rd("stall_pc4", 32'd4, 32'h2009_000C, 1'b0);
        rd("stall_pc8", 32'd8, 32'hAC08_0004, 1'b0);
        bus.pc = 32'd0;

        // Overflow: four words fill DEPTH=4, fifth is never accepted
        start_pulse();
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        send(32'h3333_3333, 1'b0);
        send(32'h4444_4444, 1'b0);
        expect_obs("ovf_edge", mk(3'd4, 0, 0, 1, 0, 0, 32'h0), M_CNT | M_FLG);
        bus.load_valid = 1'b1; bus.load_data = 32'h5555_5555;
        tick();
        expect_obs("ovf_done", mk(3'd4, 0, 1, 1, 1, 0, 32'h1111_1111), M_ALL);
        tick();
        expect_obs("ovf_no5th", mk(3'd4, 0, 1, 1, 1, 0, 32'h1111_1111), M_ALL);
        tick();
        bus.load_valid = 1'b0;
        bus.pc = 32'd12;
        expect_obs("ovf_pc12", mk(3'd4, 0, 1, 1, 1, 0, 32'h4444_4444), M_ALL);
        tick();
        bus.pc = 32'd0;

        // Reload while running
        start_pulse();
        expect_obs("reload_run", mk(3'd0, 0, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        send(32'hA000_0001, 1'b0);
        send(32'hB000_0002, 1'b1);
        tick();
        rd("reload_pc0", 32'd0, 32'hA000_0001, 1'b0);
        rd("reload_pc4", 32'd4, 32'hB000_0002, 1'b0);
        rd("reload_pc8", 32'd8, 32'h3333_3333, 1'b0);
        bus.pc = 32'd0;

        // Async reset mid-load
        start_pulse();
        send(32'hCAFE_0001, 1'b0);
        send(32'hCAFE_0002, 1'b0);
        expect_obs("async_rst", mk(3'd0, 0, 0, 0, 0, 0, 32'h0), M_CNT | M_FLG);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        expect_obs("post_rst_idle", mk(3'd0, 0, 0, 0, 0, 0, 32'h0), M_ALL);
        tick();

        // Bad pc in RUN
        start_pulse();
        send(32'h0000_0AAA, 1'b0);
        send(32'h0000_0BBB, 1'b1);
        tick();
        rd("bad_pc_misalign", 32'h2, 32'h0, 1'b1);
        rd("bad_pc_range", DEPTH * 4, 32'h0, 1'b1);
        rd("good_pc0", 32'h0, 32'h0000_0AAA, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
